// File: rtl/mem_access_unit.sv
// mem_access_unit: big-endian load/store initiator for a 32-bit data memory.
// Optional: define MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module mem_access_unit #(
    parameter int MEM_BYTES = 44
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic        r_write, r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_word;
    logic [31:0] aligned, lane, ext, mask, merged;
    logic [4:0]  shift;
    logic        acc_fault;
    logic [32:0] range_end;

    // Fault decision taken on the live request fields at accept time
    always_comb begin
        if (req_size == 2'b10)
            range_end = {1'b0, req_addr};
        else
            range_end = {1'b0, req_addr[31:2], 2'b00};
        range_end = range_end + 33'd3;
        acc_fault = (req_size == 2'b11) ||
                    (range_end > 33'(MEM_BYTES - 1));
`ifdef MEM_ALIGN_CHECK_EN
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            acc_fault = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            acc_fault = 1'b1;
`endif
    end

    // Big-endian lane position, load extension and store merge
    always_comb begin
        aligned = {r_addr[31:2], 2'b00};
        shift   = 5'd0;
        if (r_size == 2'b00)
            shift = {~r_addr[1:0], 3'b000};
        else if (r_size == 2'b01)
            shift = {~r_addr[1], 4'b0000};
        lane = mem_rdata >> shift;
        case (r_size)
            2'b00:   ext = {{24{r_signed & lane[7]}}, lane[7:0]};
            2'b01:   ext = {{16{r_signed & lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
        if (r_size == 2'b00)
            mask = 32'h0000_00ff;
        else
            mask = 32'h0000_ffff;
        merged = (r_word & ~(mask << shift)) |
                 ((r_wdata & mask) << shift);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and memory/handshake strobes
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (acc_fault)
                        state_nx = RESP;
                    else if (!req_write || req_size != 2'b10)
                        state_nx = READ;
                    else
                        state_nx = WRITE;
                end
            end
            READ: begin
                mem_read = 1'b1;
                mem_addr = (r_size == 2'b10) ? r_addr : aligned;
                state_nx = r_write ? WRITE : RESP;
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = (r_size == 2'b10) ? r_addr : aligned;
                mem_wdata = (r_size == 2'b10) ? r_wdata : merged;
                state_nx  = RESP;
            end
            default: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nx = IDLE;
            end
        endcase
    end

    // Request capture, read-word capture and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_word     <= 32'd0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_signed   <= req_signed;
                        r_size     <= req_size;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        resp_rdata <= 32'd0;
                        resp_fault <= acc_fault;
                    end
                end
                READ: begin
                    r_word <= mem_rdata;
                    if (!r_write)
                        resp_rdata <= ext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized check of mem_access_unit against a byte-array model.
// Honours MEM_ALIGN_CHECK_EN the same way as the design build.
module tb_mem_access_unit;

    localparam int MB = 44;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [7:0]  mem_b    [0:MB-1];
    logic [7:0]  fill_val [0:MB-1];
    logic [7:0]  ref_mem  [0:MB-1];
    logic        fill_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    // Byte-addressed big-endian memory, combinational read
    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 4; k++)
            if ({1'b0, mem_addr} + 33'(k) < 33'(MB))
                mem_rdata[31-8*k -: 8] = mem_b[int'(mem_addr) + k];
    end

    // Memory write port, plus bulk preload
    always @(posedge clk) begin
        if (fill_en)
            mem_b <= fill_val;
        else if (mem_write)
            for (int k = 0; k < 4; k++)
                if ({1'b0, mem_addr} + 33'(k) < 33'(MB))
                    mem_b[int'(mem_addr) + k] <= mem_wdata[31-8*k -: 8];
    end

    task automatic preload();
        @(negedge clk);
        fill_en = 1'b1;
        @(posedge clk);
        #1 fill_en = 1'b0;
        ref_mem = fill_val;
    endtask

    // Reference: plain byte-array semantics of each request
    task automatic model(input bit w, input logic [1:0] sz,
                         input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, output bit f,
                         output logic [31:0] rd, output int lat);
        int n, start;
        logic [32:0] last;
        logic [31:0] v;
        f  = 1'b0;
        rd = 32'd0;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd2)
            last = {1'b0, a} + 33'd3;
        else
            last = {1'b0, a & 32'hffff_fffc} + 33'd3;
        if (sz == 2'd3 || last > 33'(MB - 1))
            f = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
        if (sz == 2'd2 && a % 4 != 0) f = 1'b1;
        if (sz == 2'd1 && a % 2 != 0) f = 1'b1;
`endif
        if (sz == 2'd1)
            start = int'(a & 32'hffff_fffc) + (a[1] ? 2 : 0);
        else
            start = int'(a);
        if (!f) begin
            if (w) begin
                for (int i = 0; i < n; i++)
                    ref_mem[start+i] = wd[8*(n-1-i) +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++)
                    v = (v << 8) | 32'(ref_mem[start+i]);
                if (sg && n < 4 && v[8*n-1])
                    v = v | (32'hffff_ffff << (8*n));
                rd = v;
            end
        end
        lat = f ? 1 : (!w ? 2 : (n == 4 ? 2 : 3));
    endtask

    // One full transaction; records latency and strobes seen
    task automatic do_req(input bit w, input logic [1:0] sz,
                          input bit sg, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd, output bit f,
                          output int lat, output int nrd,
                          output int nwr, output logic [31:0] wa,
                          output logic [31:0] wdat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat  = 0;
        nrd  = 0;
        nwr  = 0;
        wa   = 32'd0;
        wdat = 32'd0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n;
                break;
            end
            nrd += int'(mem_read);
            nwr += int'(mem_write);
            if (mem_write) begin
                wa   = mem_addr;
                wdat = mem_wdata;
            end
        end
        rd = resp_rdata;
        f  = resp_fault;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_strobes got=%b%b exp=00",
                     mem_read, mem_write);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_req_ready got=%b exp=1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_fault !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp got=%b%b exp=00",
                     resp_valid, resp_fault);
        end
        checks++;
        if (resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_rdata got=%h exp=0", resp_rdata);
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_mem_bus got=%h/%h exp=0/0",
                     mem_addr, mem_wdata);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd, wa, wd;
        bit f;
        int lat, nrd, nwr;
        do_req(0, 2'd2, 0, 32'd8, 0, rd, f, lat, nrd, nwr, wa, wd);
        checks++;
        if (rd !== 32'h1 || f !== 1'b0) begin
            errors++;
            $display("FAIL ldw8 got=%h/%b exp=00000001/0", rd, f);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL ldw8_lat got=%0d exp=2", lat);
        end
        do_req(1, 2'd0, 0, 32'd5, 32'hAB, rd, f, lat, nrd, nwr, wa, wd);
        checks++;
        if (nrd !== 1 || nwr !== 1 || lat !== 3) begin
            errors++;
            $display("FAIL stb5_seq got=r%0d w%0d l%0d exp=r1 w1 l3",
                     nrd, nwr, lat);
        end
        checks++;
        if (wa !== 32'd4 || wd !== 32'h00AB0001) begin
            errors++;
            $display("FAIL stb5_wr got=%h@%h exp=00ab0001@4", wd, wa);
        end
        do_req(0, 2'd0, 1, 32'd5, 0, rd, f, lat, nrd, nwr, wa, wd);
        checks++;
        if (rd !== 32'hFFFFFFAB) begin
            errors++;
            $display("FAIL ldbs5 got=%h exp=ffffffab", rd);
        end
        do_req(0, 2'd0, 0, 32'd5, 0, rd, f, lat, nrd, nwr, wa, wd);
        checks++;
        if (rd !== 32'h000000AB) begin
            errors++;
            $display("FAIL ldbu5 got=%h exp=000000ab", rd);
        end
        do_req(1, 2'd1, 0, 32'd10, 32'h1234, rd, f, lat, nrd, nwr,
               wa, wd);
        checks++;
        if (wa !== 32'd8 || wd !== 32'h00001234) begin
            errors++;
            $display("FAIL sth10_wr got=%h@%h exp=00001234@8", wd, wa);
        end
        do_req(0, 2'd2, 0, 32'd8, 0, rd, f, lat, nrd, nwr, wa, wd);
        checks++;
        if (rd !== 32'h00001234) begin
            errors++;
            $display("FAIL ldw8b got=%h exp=00001234", rd);
        end
        do_req(0, 2'd1, 1, 32'd10, 0, rd, f, lat, nrd, nwr, wa, wd);
        checks++;
        if (rd !== 32'h00001234) begin
            errors++;
            $display("FAIL ldhs10 got=%h exp=00001234", rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd, wa, wd;
        bit f;
        int lat, nrd, nwr;
        do_req(0, 2'd2, 0, 32'd44, 0, rd, f, lat, nrd, nwr, wa, wd);
        checks++;
        if (f !== 1'b1 || lat !== 1 || nrd + nwr !== 0) begin
            errors++;
            $display("FAIL flt44 got=f%b l%0d s%0d exp=f1 l1 s0",
                     f, lat, nrd + nwr);
        end
        do_req(1, 2'd3, 0, 32'd0, 32'h5, rd, f, lat, nrd, nwr, wa, wd);
        checks++;
        if (f !== 1'b1 || lat !== 1 || nrd + nwr !== 0) begin
            errors++;
            $display("FAIL flt_sz3 got=f%b l%0d s%0d exp=f1 l1 s0",
                     f, lat, nrd + nwr);
        end
        do_req(0, 2'd2, 0, 32'hFFFF_FFFE, 0, rd, f, lat, nrd, nwr,
               wa, wd);
        checks++;
        if (f !== 1'b1 || rd !== 32'd0 || nrd !== 0) begin
            errors++;
            $display("FAIL flt_wrap got=f%b d%h r%0d exp=f1 d0 r0",
                     f, rd, nrd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd0;
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'd8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 6);
        rd0 = resp_rdata;
        checks++;
        if (resp_valid !== 1'b1 || rd0 !== 32'h00001234) begin
            errors++;
            $display("FAIL bp_first got=v%b d%h exp=v1 d00001234",
                     resp_valid, rd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h00001234 ||
                resp_fault !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got=v%b d%h f%b r%b",
                         i, resp_valid, resp_rdata, resp_fault,
                         req_ready);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_done got=v%b r%b exp=v0 r1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'd0;
        req_addr   = 32'd6;
        req_wdata  = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rmw_read got=%b exp=1", mem_read);
        end
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rmw_write got=%b exp=1", mem_write);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmw_rst_drop got=w%b v%b exp=w0 v0",
                     mem_write, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_b[4], mem_b[5], mem_b[6], mem_b[7]} !== 32'h00AB0001) begin
            errors++;
            $display("FAIL rmw_word got=%h exp=00ab0001",
                     {mem_b[4], mem_b[5], mem_b[6], mem_b[7]});
        end
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmw_idle got=v%b r%b exp=v0 r1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_misaligned_word();
        logic [31:0] rd, wa, wd;
        bit f;
        int lat, nrd, nwr;
        do_req(1, 2'd2, 0, 32'd2, 32'hCAFEF00D, rd, f, lat, nrd, nwr,
               wa, wd);
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (f !== 1'b1 || nwr !== 0 || lat !== 1) begin
            errors++;
            $display("FAIL msw2 got=f%b w%0d l%0d exp=f1 w0 l1",
                     f, nwr, lat);
        end
`else
        checks++;
        if (f !== 1'b0 || nwr !== 1 || wa !== 32'd2 || lat !== 2) begin
            errors++;
            $display("FAIL msw2 got=f%b w%0d a%h l%0d exp=f0 w1 a2 l2",
                     f, nwr, wa, lat);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, wa, wd, erd, a, d;
        logic [1:0] sz;
        bit f, ef, w, sg;
        int lat, elat, nrd, nwr, ew, er;
        for (int i = 0; i < MB; i++)
            fill_val[i] = 8'($urandom);
        preload();
        for (int t = 0; t < 300; t++) begin
            w  = 1'($urandom);
            sg = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 :
                 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0)
                a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else
                a = 32'($urandom_range(0, 47));
            d = $urandom;
            model(w, sz, sg, a, d, ef, erd, elat);
            do_req(w, sz, sg, a, d, rd, f, lat, nrd, nwr, wa, wd);
            ew = (!ef && w) ? 1 : 0;
            er = (!ef && (!w || sz != 2'd2)) ? 1 : 0;
            checks++;
            if (rd !== erd || f !== ef) begin
                errors++;
                $display("FAIL rnd%0d_resp got=%h/%b exp=%h/%b",
                         t, rd, f, erd, ef);
            end
            checks++;
            if (lat !== elat || nrd !== er || nwr !== ew) begin
                errors++;
                $display("FAIL rnd%0d_seq got=l%0d r%0d w%0d exp=l%0d r%0d w%0d",
                         t, lat, nrd, nwr, elat, er, ew);
            end
        end
        for (int i = 0; i < MB; i++) begin
            checks++;
            if (mem_b[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL rnd_mem%0d got=%h exp=%h",
                         i, mem_b[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        fill_en    = 1'b0;
        for (int i = 0; i < MB; i++)
            fill_val[i] = (i % 4 == 3) ? 8'h01 : 8'h00;
        preload();
        test_reset();
        test_basic();
        test_faults();
        test_backpressure();
        test_reset_mid_write();
        test_misaligned_word();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
